// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: grants one producer result per cycle onto we3/wa3/wd3 and tracks pending writes.
// Build option WB_RR_EN selects round-robin arbitration; when undefined, the lowest-index valid source wins.
module wb_arbiter #(
  parameter int N_SRC = 3,
  parameter int XLEN  = 32,
  parameter int RA    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [N_SRC*RA-1:0]   src_rd,
  input  logic [N_SRC*XLEN-1:0] src_data,
  output logic [N_SRC-1:0]      src_ready,
  input  logic                  set_en,
  input  logic [RA-1:0]         set_rd,
  output logic                  we3,
  output logic [RA-1:0]         wa3,
  output logic [XLEN-1:0]       wd3,
  output logic [(2**RA)-1:0]    pending,
  output logic                  busy
);
  localparam int PW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int NREG = 2**RA;

  logic [N_SRC-1:0] grant;
  logic [PW-1:0]    gnt_idx;
  logic             found;
  logic             hs;
  logic [RA-1:0]    gnt_rd;
  logic [XLEN-1:0]  gnt_data;

  logic             we3_q, we3_d;
  logic [RA-1:0]    wa3_q, wa3_d;
  logic [XLEN-1:0]  wd3_q, wd3_d;
  logic [NREG-1:0]  pending_q, pending_d;

`ifdef WB_RR_EN
  localparam logic [PW:0]   N_SRC_W  = (PW+1)'(N_SRC);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_SRC-1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   cand;

  // Scan upward from the pointer with wrap; first valid source wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= N_SRC_W) cand = cand - N_SRC_W;
      if (!found && src_valid[cand[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
    if (found) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && src_valid[PW'(k)]) begin
        found   = 1'b1;
        gnt_idx = PW'(k);
      end
    end
    if (found) grant[gnt_idx] = 1'b1;
  end
`endif

  // A grant during reset is void, so the handshake is masked here.
  assign src_ready = reset ? '0 : grant;
  assign hs        = |src_ready;
  assign gnt_rd    = src_rd[gnt_idx*RA +: RA];
  assign gnt_data  = src_data[gnt_idx*XLEN +: XLEN];
  assign busy      = |src_valid;

  always_comb begin
    we3_d = hs && (gnt_rd != '0);
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (we3_d) begin
      wa3_d = gnt_rd;
      wd3_d = gnt_data;
    end
    // Clear first so a same-cycle set of the same register (newer producer) wins.
    pending_d = pending_q;
    if (we3_q) pending_d[wa3_q] = 1'b0;
    if (set_en && (set_rd != '0)) pending_d[set_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q     <= 1'b0;
      wa3_q     <= '0;
      wd3_q     <= '0;
      pending_q <= '0;
    end else begin
      we3_q     <= we3_d;
      wa3_q     <= wa3_d;
      wd3_q     <= wd3_d;
      pending_q <= pending_d;
    end
  end

  assign we3     = we3_q;
  assign wa3     = wa3_q;
  assign wd3     = wd3_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic against a cycle-level reference model.
// Honours WB_RR_EN the same way as the design (round-robin when defined, fixed priority otherwise).
module tb_wb_arbiter;
  localparam int N    = 3;
  localparam int XLEN = 32;
  localparam int RA   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      src_valid;
  logic [N*RA-1:0]   src_rd;
  logic [N*XLEN-1:0] src_data;
  logic [N-1:0]      src_ready;
  logic              set_en;
  logic [RA-1:0]     set_rd;
  logic              we3;
  logic [RA-1:0]     wa3;
  logic [XLEN-1:0]   wd3;
  logic [31:0]       pending;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr = 0;
  logic        m_we  = 1'b0;
  logic [4:0]  m_wa  = '0;
  logic [31:0] m_wd  = '0;
  logic [31:0] m_pend = '0;

  wb_arbiter #(.N_SRC(N), .XLEN(XLEN), .RA(RA)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_rd(src_rd),
    .src_data(src_data), .src_ready(src_ready), .set_en(set_en), .set_rd(set_rd),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (reset) return -1;
    for (int k = 0; k < N; k++) begin
`ifdef WB_RR_EN
      int i = (m_ptr + k) % N;
`else
      int i = k;
`endif
      if (src_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic raise(input int s, input int rd, input logic [31:0] d);
    src_valid[s]           = 1'b1;
    src_rd[s*RA +: RA]     = RA'(rd);
    src_data[s*XLEN +: XLEN] = d;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model at the edge, check registered outputs after.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    logic [4:0]   r;
    @(negedge clk);
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("src_ready", 64'(src_ready), 64'(exp_rdy));
    check("busy", 64'(busy), 64'(|src_valid));
    @(posedge clk);
    if (reset) begin
      m_we = 1'b0; m_wa = '0; m_wd = '0; m_pend = '0; m_ptr = 0;
    end else begin
      if (m_we) m_pend[m_wa] = 1'b0;
      if (set_en && set_rd != 0) m_pend[set_rd] = 1'b1;
      m_we = 1'b0;
      if (g >= 0) begin
        r = src_rd[g*RA +: RA];
        if (r != 0) begin
          m_we = 1'b1;
          m_wa = r;
          m_wd = src_data[g*XLEN +: XLEN];
        end
        m_ptr = (g + 1) % N;
        $display("txn t=%0t src=%0d rd=%0d data=%h", $time, g, r, src_data[g*XLEN +: XLEN]);
      end
    end
    #1;
    check("we3", 64'(we3), 64'(m_we));
    if (m_we) begin
      check("wa3", 64'(wa3), 64'(m_wa));
      check("wd3", 64'(wd3), 64'(m_wd));
    end
    check("pending", 64'(pending), 64'(m_pend));
    if (g >= 0) src_valid[g] = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_valid = '0; src_rd = '0; src_data = '0; set_en = 1'b0; set_rd = '0;
    cycle(); cycle();
    check("rst_wa3", 64'(wa3), 64'd0);
    check("rst_wd3", 64'(wd3), 64'd0);
    reset = 1'b0;

    // Single write
    raise(0, 5, 32'hDEADBEEF);
    cycle();
    check("single_we3", 64'(we3), 64'd1);
    check("single_wa3", 64'(wa3), 64'd5);
    check("single_wd3", 64'(wd3), 64'hDEADBEEF);
    cycle();
    check("single_idle", 64'(we3), 64'd0);

    // Arbitration order from a freshly reset pointer
    reset = 1'b1; cycle(); reset = 1'b0;
    raise(0, 1, 32'h1111_0000); raise(1, 2, 32'h2222_0000); raise(2, 3, 32'h3333_0000);
    for (int k = 0; k < 3; k++) begin
      cycle();
`ifdef WB_RR_EN
      check("rr_wa3", 64'(wa3), 64'(k + 1));
`else
      check("fp_wa3", 64'(wa3), 64'd1);
`endif
      if (k < 2 && !src_valid[0]) raise(0, 1, 32'h1111_0000 + 32'(k));
    end
    repeat (4) cycle();

    // x0 destination: handshake completes, no write
    raise(1, 0, 32'h1234);
    cycle();
    check("x0_we3", 64'(we3), 64'd0);

    // Scoreboard set / clear
    set_en = 1'b1; set_rd = 5'd7;
    cycle();
    set_en = 1'b0;
    check("pend7_set", 64'(pending[7]), 64'd1);
    raise(2, 7, 32'h7777_7777);
    cycle();
    check("pend7_wcycle", 64'(pending[7]), 64'd1);
    cycle();
    check("pend7_clear", 64'(pending[7]), 64'd0);
    set_en = 1'b1; set_rd = 5'd0;
    cycle();
    set_en = 1'b0;
    check("pend_x0", 64'(pending), 64'd0);

    // Same-register set and clear collide: set wins
    set_en = 1'b1; set_rd = 5'd9;
    cycle();
    set_en = 1'b0;
    raise(0, 9, 32'h9999_9999);
    cycle();
    set_en = 1'b1; set_rd = 5'd9;
    cycle();
    set_en = 1'b0;
    check("collide_p9", 64'(pending[9]), 64'd1);

    // Reset in the middle of traffic
    raise(0, 4, 32'h4444_4444); raise(1, 6, 32'h6666_6666);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_mid_we3", 64'(we3), 64'd0);
    check("rst_mid_pend", 64'(pending), 64'd0);
    cycle();
    check("rst_first_wa3", 64'(wa3), 64'd4);
    repeat (2) cycle();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < N; s++)
        if (!src_valid[s] && $urandom_range(0, 1) == 1)
          raise(s, int'($urandom_range(0, 31)), $urandom);
      set_en = ($urandom_range(0, 2) == 0);
      set_rd = RA'($urandom_range(0, 31));
      reset  = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset = 1'b0; set_en = 1'b0;
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writer side of the core's integer register file write port (we3/wa3/wd3). Collects results from N_SRC producers (ALU, load unit, multi-cycle mul/div/FPU-int) over valid/ready handshakes and grants one per cycle. Drives a registered write onto the register file. Maintains a pending-write scoreboard that the decode stage uses for RAW-hazard stalls.

Parameters:
N_SRC, 3, number of result producers; source index 0..N_SRC-1
XLEN, 32, register data width
RA, 5, register address width (32 architectural registers)

Ports:
clk  input  1  clock
reset  input  1  synchronous reset, active-high
src_valid  input  N_SRC  per-source result valid
src_rd  input  N_SRC*RA  per-source destination register, source i in bits [i*RA +: RA]
src_data  input  N_SRC*XLEN  per-source result, source i in bits [i*XLEN +: XLEN]
src_ready  output  N_SRC  per-source grant; handshake completes when src_valid[i] and src_ready[i] are both 1
set_en  input  1  decode issued an instruction that will write set_rd
set_rd  input  RA  destination register being marked pending
we3  output  1  register file write enable
wa3  output  RA  register file write address
wd3  output  XLEN  register file write data
pending  output  2**RA  scoreboard; bit r=1 means a write to register r is outstanding
busy  output  1  OR of src_valid; at least one result is waiting

Behaviour:
- Reset (synchronous, clk edge with reset=1): we3=0, wa3=0, wd3=0, pending=0, priority pointer=0. src_ready is combinational and is forced to 0 while reset=1.
- Reset mid-operation: any grant in the reset cycle is void. we3=0 in the cycle after reset. The scoreboard is cleared.
- Source protocol: once asserted, src_valid[i], src_rd and src_data are held stable until a handshake. A source must not drop valid without a handshake.
- Grant: src_ready is combinational from src_valid and the pointer, with no dependence on any ready input. The write port is never back-pressured, so exactly one valid source is granted whenever any is valid. src_ready is one-hot or zero.
- Arbitration is round-robin by default. Scan starts at the pointer, upward with wrap. After granting source g, pointer <= (g+1) mod N_SRC. The pointer is unchanged when there is no grant.
- Write latency: handshake in cycle N gives we3=1, wa3=src_rd[g], wd3=src_data[g] in cycle N+1. The register file captures at the end of N+1.
- No grant in cycle N gives we3=0 in N+1. wa3 and wd3 hold their last values.
- x0: a granted result with rd=0 still completes its handshake. It produces we3=0 in N+1 and has no scoreboard effect.
- Scoreboard set: set_en=1 and set_rd!=0 gives pending[set_rd]<=1 at end of cycle. set_rd=0 is ignored. pending[0] is always 0.
- Scoreboard clear: when we3=1 in cycle M, pending[wa3]<=0 at the end of M. From M+1 pending is 0 and the register file holds the new value.
- Set and clear of the same register in the same cycle: set wins, because it is a newer producer. Set and clear of different registers both take effect.
- Setting an already-pending register keeps it at 1. No counting; decode never issues two outstanding writers to the same register.
- busy = |src_valid, combinational.

Optional Feature:
WB_RR_EN: defined (the build default) selects round-robin arbitration as above. Undefined selects fixed priority, where the lowest-index valid source wins. In that case the pointer register is removed, and source 0 (ALU) can starve the others by design. All other behaviour is identical in both builds.

Test Plan:
- Single write: reset, then src_valid=3'b001, src_rd[0]=5, src_data[0]=0xDEADBEEF for one cycle -> src_ready=3'b001 that cycle; next cycle we3=1, wa3=5, wd3=0xDEADBEEF; following cycle we3=0.
- Round-robin: all three sources valid and held (rd 1,2,3) -> grants in cycles 0,1,2 are src0, src1, src2; we3 writes to 1,2,3 in cycles 1,2,3. Without WB_RR_EN: src0 granted every cycle while valid.
- x0 drop: src1 valid with rd=0, data=0x1234 -> src_ready[1]=1; next cycle we3=0; pending unchanged.
- Scoreboard: set_en with rd=7 -> pending[7]=1; src2 writes rd=7 -> pending[7]=1 during the we3 cycle, 0 the cycle after. set_en with rd=0 -> pending stays 0.
- Set/clear collision: pending[9]=1 and a we3 write to 9 in cycle M, while set_en with rd=9 in M -> pending[9]=1 at M+1.
- Reset mid-op: src0 valid and reset=1 in the same cycle -> src_ready=0; next cycle we3=0 and pending=0; pointer=0, so src0 wins first after reset in round-robin mode.
